// File: rtl/snoop_dispatch_if.sv
// Snooper-to-dispatcher bus: snooper write port on one side, per-core
// forwarding port plus drop counter on the other.
interface snoop_dispatch_if #(
    parameter int unsigned PACKMEM_ADDR_WIDTH = 8,
    parameter int unsigned PACKMEM_DATA_WIDTH = 64,
    parameter int unsigned INC_WIDTH          = 8,
    parameter int unsigned N                  = 4,
    parameter int unsigned CNT_WIDTH          = 16
);
    logic [PACKMEM_ADDR_WIDTH-1:0] addr;
    logic [PACKMEM_DATA_WIDTH-1:0] wr_data;
    logic                          wr_en;
    logic [INC_WIDTH-1:0]          byte_inc;
    logic                          done;
    logic                          rdy;
    logic [N-1:0]                  rdy_for_sn;
    logic [N-1:0]                  rdy_for_sn_ack;
    logic [PACKMEM_ADDR_WIDTH-1:0] sn_addr;
    logic [PACKMEM_DATA_WIDTH-1:0] sn_wr_data;
    logic [INC_WIDTH-1:0]          sn_byte_inc;
    logic [N-1:0]                  sn_wr_en;
    logic [N-1:0]                  sn_done;
    logic [CNT_WIDTH-1:0]          drop_cnt;

    // Stimulus side: snooper and cores.
    modport master (
        output addr, wr_data, wr_en, byte_inc, done, rdy_for_sn,
        input  rdy, rdy_for_sn_ack, sn_addr, sn_wr_data, sn_byte_inc, sn_wr_en, sn_done,
               drop_cnt
    );

    // Dispatcher side.
    modport slave (
        input  addr, wr_data, wr_en, byte_inc, done, rdy_for_sn,
        output rdy, rdy_for_sn_ack, sn_addr, sn_wr_data, sn_byte_inc, sn_wr_en, sn_done,
               drop_cnt
    );
endinterface

// File: rtl/snoop_dispatch.sv
// Binds the packet snooper to one of N packetfilter cores per packet and
// forwards its writes with one cycle of latency. A core that withdraws its
// ready mid-packet causes the rest of the packet to be swallowed and counted.
module snoop_dispatch #(
    parameter int unsigned PACKMEM_ADDR_WIDTH = 8,
    parameter int unsigned PACKMEM_DATA_WIDTH = 64,
    parameter int unsigned INC_WIDTH          = 8,
    parameter int unsigned N                  = 4,
    parameter int unsigned MODE               = 0,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input logic             clk,
    input logic             rst,
    snoop_dispatch_if.slave bus
);
    localparam int unsigned SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t                        state;
    logic [SEL_WIDTH-1:0]          sel;
    logic [SEL_WIDTH-1:0]          ptr;
    logic [N-1:0]                  ack_q;
    logic                          rdy_q;
    logic [PACKMEM_ADDR_WIDTH-1:0] addr_q;
    logic [PACKMEM_DATA_WIDTH-1:0] data_q;
    logic [INC_WIDTH-1:0]          inc_q;
    logic [N-1:0]                  wr_en_q;
    logic [N-1:0]                  done_q;
    logic [CNT_WIDTH-1:0]          drop_q;

    logic [SEL_WIDTH-1:0]          pick;
    logic [SEL_WIDTH-1:0]          pick_next;
    logic [N-1:0]                  pick_onehot;
    logic [N-1:0]                  sel_onehot;

    // Choose the next core: first ready core at or above the search base, wrapping.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        logic        found;
        base  = (MODE == 0) ? 32'(ptr) : 32'd0;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = base + off;
            if (idx >= N) idx = idx - N;
            if (!found && bus.rdy_for_sn[SEL_WIDTH'(idx)]) begin
                found = 1'b1;
                pick  = SEL_WIDTH'(idx);
            end
        end
        pick_next   = (32'(pick) == N - 1) ? '0 : pick + 1'b1;
        pick_onehot = N'(1) << pick;
        sel_onehot  = N'(1) << sel;
    end

    // Dispatch FSM. The grant pulse is registered in IDLE; the following edge
    // commits to ACTIVE, so a grant always costs at least one IDLE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sel     <= '0;
            ptr     <= '0;
            ack_q   <= '0;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            inc_q   <= '0;
            wr_en_q <= '0;
            done_q  <= '0;
            drop_q  <= '0;
        end else begin
            ack_q   <= '0;
            wr_en_q <= '0;
            done_q  <= '0;
            case (state)
                IDLE: begin
                    if (ack_q != '0) begin
                        state <= ACTIVE;
                        rdy_q <= 1'b1;
                    end else if (bus.rdy_for_sn != '0) begin
                        sel   <= pick;
                        ptr   <= pick_next;
                        ack_q <= pick_onehot;
                    end
                end
                ACTIVE: begin
                    addr_q <= bus.addr;
                    data_q <= bus.wr_data;
                    inc_q  <= bus.byte_inc;
                    if (bus.done) begin
                        // done beats a simultaneous loss of ready
                        wr_en_q <= bus.wr_en ? sel_onehot : '0;
                        done_q  <= sel_onehot;
                        state   <= IDLE;
                        rdy_q   <= 1'b0;
                    end else if (!bus.rdy_for_sn[sel]) begin
                        state <= FLUSH;
                        if (drop_q != '1) drop_q <= drop_q + 1'b1;
                    end else begin
                        wr_en_q <= bus.wr_en ? sel_onehot : '0;
                    end
                end
                FLUSH: begin
                    if (bus.done) begin
                        state <= IDLE;
                        rdy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdy            = rdy_q;
    assign bus.rdy_for_sn_ack = ack_q;
    assign bus.sn_addr        = addr_q;
    assign bus.sn_wr_data     = data_q;
    assign bus.sn_byte_inc    = inc_q;
    assign bus.sn_wr_en       = wr_en_q;
    assign bus.sn_done        = done_q;
    assign bus.drop_cnt       = drop_q;
endmodule
